// File: rtl/comp2_decode_if.sv
// comp2_decode_if
// Handshake and data bundle for the two's-complement difference decoder.
//   in_valid/in_ready   : input handshake for diff and of_in
//   diff, of_in         : 8-bit two's-complement difference and its overflow flag
//   out_valid/out_ready : output handshake for the decoded result
//   sign, mag, bcd      : sign-magnitude form and 3-digit BCD of the magnitude
//   of_out              : overflow flag, masked to 0 when diff is zero
// The master modport is the producer/consumer side; the slave modport is the decoder.
interface comp2_decode_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  diff;
  logic        of_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [7:0]  mag;
  logic [11:0] bcd;
  logic        of_out;

  modport master (
    output in_valid, diff, of_in, out_ready,
    input  in_ready, out_valid, sign, mag, bcd, of_out
  );

  modport slave (
    input  in_valid, diff, of_in, out_ready,
    output in_ready, out_valid, sign, mag, bcd, of_out
  );
endinterface

// File: rtl/comp2_decode.sv
// comp2_decode
// Converts an 8-bit two's-complement difference into sign-magnitude form plus a
// 3-digit BCD magnitude using an iterative double-dabble loop (8 iterations).
//   clk   : rising-edge clock
//   reset : asynchronous, active-low; returns to IDLE and clears all outputs
//   bus   : comp2_decode_if.slave carrying both handshakes, inputs and results
// One result every 11 cycles when the consumer never stalls; in_ready is only
// high in IDLE, so nothing is buffered while a conversion is in flight.
module comp2_decode (
  input  logic               clk,
  input  logic               reset,
  comp2_decode_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, NEG, CONV, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  diff_q;
  logic        ofIn_q;
  logic [19:0] shift_q;
  logic [2:0]  cnt_q;
  logic        outValid_q;
  logic        sign_q;
  logic [7:0]  mag_q;
  logic [11:0] bcd_q;
  logic        ofOut_q;

  logic [7:0]  magCalc;
  logic [19:0] shiftAdj;
  logic [19:0] shiftStep;
  logic        lastIter;

  // Magnitude of the captured difference. 8'h80 negates to itself, which read
  // as unsigned is exactly 128, so 8 bits are enough.
  assign magCalc  = diff_q[7] ? (~diff_q + 8'd1) : diff_q;
  assign lastIter = (state_q == CONV) && (cnt_q == 3'd7);

  // One double-dabble iteration: correct every BCD nibble that would overflow
  // a decimal digit when doubled, then shift the whole register left.
  always_comb begin
    shiftAdj = shift_q;
    for (int k = 0; k < 3; k++) begin
      if (shiftAdj[8 + 4*k +: 4] >= 4'd5) begin
        shiftAdj[8 + 4*k +: 4] = shiftAdj[8 + 4*k +: 4] + 4'd3;
      end
    end
    shiftStep = {shiftAdj[18:0], 1'b0};
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = NEG;
      NEG:  state_d = CONV;
      CONV: if (cnt_q == 3'd7) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture on acceptance, load the shifter in NEG, iterate in CONV
  // and publish results only on the edge that enters DONE so outputs never
  // show partial conversions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      diff_q     <= 8'd0;
      ofIn_q     <= 1'b0;
      shift_q    <= 20'd0;
      cnt_q      <= 3'd0;
      outValid_q <= 1'b0;
      sign_q     <= 1'b0;
      mag_q      <= 8'd0;
      bcd_q      <= 12'd0;
      ofOut_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            diff_q <= bus.diff;
            ofIn_q <= bus.of_in;
          end
        end
        NEG: begin
          shift_q <= {12'd0, magCalc};
          cnt_q   <= 3'd0;
        end
        CONV: begin
          shift_q <= shiftStep;
          cnt_q   <= cnt_q + 3'd1;
          if (lastIter) begin
            sign_q     <= diff_q[7];
            mag_q      <= magCalc;
            bcd_q      <= shiftStep[19:8];
            ofOut_q    <= ofIn_q & (diff_q != 8'd0);
            outValid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) outValid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = outValid_q;
  assign bus.sign      = sign_q;
  assign bus.mag       = mag_q;
  assign bus.bcd       = bcd_q;
  assign bus.of_out    = ofOut_q;

endmodule

// File: tb/tb_comp2_decode.sv
// tb_comp2_decode
// Scoreboard bench for comp2_decode: the stimulus side pushes the expected
// result of every accepted input, and an independent monitor pops and compares
// whenever a result transfers. Expected values come from signed arithmetic and
// decimal division, not from any shift-and-add formulation.
module tb_comp2_decode;

  typedef struct {
    logic        sign;
    logic [7:0]  mag;
    logic [11:0] bcd;
    logic        of;
  } exp_t;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   lastAccept = 0;
  int   prevAccept = 0;
  bit   checkInterval = 0;
  bit   prevValid = 0;
  exp_t sb[$];

  comp2_decode_if bus ();

  comp2_decode dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Reference: interpret diff as a signed integer, take its absolute value and
  // split it into decimal digits.
  function automatic exp_t refModel(input logic [7:0] d, input logic o);
    exp_t e;
    int   v;
    int   m;
    v = int'($signed(d));
    m = (v < 0) ? -v : v;
    e.sign = (v < 0);
    e.mag  = 8'(m);
    e.bcd  = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    e.of   = o && (v != 0);
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Wait for in_ready, present one input for a single edge and record the
  // expected response once it has been accepted.
  task automatic applyStimulus(input logic [7:0] d, input logic o);
    int n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      checkOutput("in_ready_timeout", 0, 1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.diff     = d;
    bus.of_in    = o;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    sb.push_back(refModel(d, o));
    prevAccept = lastAccept;
    lastAccept = cycle;
    if (checkInterval) checkOutput("accept_interval", lastAccept - prevAccept, 11);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency check on every rising out_valid, scoreboard compare on
  // every transfer.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (bus.out_valid && !prevValid) checkOutput("latency", cycle - lastAccept, 9);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("sign", bus.sign, e.sign);
          checkOutput("mag", bus.mag, e.mag);
          checkOutput("bcd", bus.bcd, e.bcd);
          checkOutput("of_out", bus.of_out, e.of);
        end
      end
    end
    prevValid = bus.out_valid;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [7:0]  dirDiff [6] = '{8'hFF, 8'h9C, 8'h80, 8'h7F, 8'h00, 8'h40};
    logic        dirOf   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        hSign;
    logic [7:0]  hMag;
    logic [11:0] hBcd;
    logic        hOf;
    int          n;

    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.diff      = 8'd0;
    bus.of_in     = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_mag", bus.mag, 0);
    checkOutput("rst_bcd", bus.bcd, 0);
    checkOutput("rst_sign", bus.sign, 0);
    checkOutput("rst_of_out", bus.of_out, 0);
    @(posedge clk);
    #3;
    reset = 1'b1;

    // Directed values: negatives, extremes and overflow masking.
    for (int i = 0; i < 6; i++) applyStimulus(dirDiff[i], dirOf[i]);
    drain();

    // Asynchronous reset in the middle of a conversion.
    applyStimulus(8'h37, 1'b1);
    repeat (3) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("midrst_out_valid", bus.out_valid, 0);
    checkOutput("midrst_mag", bus.mag, 0);
    checkOutput("midrst_bcd", bus.bcd, 0);
    checkOutput("midrst_in_ready", bus.in_ready, 1);
    sb.delete();
    @(posedge clk);
    #3;
    reset = 1'b1;
    applyStimulus(8'h05, 1'b0);
    drain();

    // Backpressure: hold the result in DONE for 20 cycles.
    bus.out_ready = 1'b0;
    applyStimulus(8'hC8, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_out_valid", bus.out_valid, 1);
    hSign = bus.sign;
    hMag  = bus.mag;
    hBcd  = bus.bcd;
    hOf   = bus.of_out;
    checkOutput("bp_mag_value", hMag, 56);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      bus.in_valid = (k % 3 == 0);
      bus.diff     = 8'($urandom);
      bus.of_in    = 1'($urandom);
      @(negedge clk);
      checkOutput("bp_in_ready", bus.in_ready, 0);
      checkOutput("bp_valid_held", bus.out_valid, 1);
      checkOutput("bp_stable", {bus.sign, bus.mag, bus.bcd, bus.of_out},
                  {hSign, hMag, hBcd, hOf});
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_release_valid", bus.out_valid, 0);
    checkOutput("bp_release_ready", bus.in_ready, 1);
    checkOutput("bp_sb_empty", sb.size(), 0);

    // Exhaustive sweep, back-to-back, random overflow flag.
    for (int v = 0; v < 256; v++) begin
      checkInterval = (v != 0);
      applyStimulus(8'(v), 1'($urandom_range(0, 1)));
    end
    checkInterval = 0;
    drain();
    checkOutput("final_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/comp2_decode.md
# comp2_decode

Sequential decoder for the 8-bit two's-complement difference produced by the ALU subtract path. It accepts a difference byte and its overflow flag over a valid/ready handshake. It returns sign-magnitude form plus a 3-digit BCD magnitude, computed by an iterative double-dabble FSM. It sits downstream of the subtractor, feeding display and compare logic that needs unsigned magnitude and decimal digits.

## Interface
- No parameters; data width fixed at 8 bits, BCD width fixed at 12 bits.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; clears all state immediately.
- in_valid  input  1  diff/of_in valid this cycle.
- in_ready  output  1  block can accept input; high only in IDLE.
- diff  input  8  two's-complement difference.
- of_in  input  1  overflow flag accompanying diff.
- out_valid  output  1  sign/mag/bcd/of_out hold a complete result.
- out_ready  input  1  consumer accepts result.
- sign  output  1  1 = diff negative.
- mag  output  8  unsigned magnitude |diff|, range 0..128.
- bcd  output  12  {hundreds, tens, ones} BCD digits of mag.
- of_out  output  1  registered overflow, forced 0 when diff == 0.

## Operation
- States: IDLE, NEG, CONV, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, register diff and of_in, then go to NEG.
- NEG (1 cycle):
  - sign_n = diff[7].
  - mag_n = diff[7] ? (~diff + 1) : diff, computed in 9 bits so 8'h80 gives 128.
  - Load the 20-bit shift register {12'd0, mag_n[7:0]}.
  - Clear the iteration counter; go to CONV.
- CONV (8 cycles):
  - Per cycle, add 3 to every BCD nibble of the shift register that is >= 5, then shift the whole register left 1.
  - Counter 0..7. After the iteration with counter == 7, go to DONE.
- Output registers load on the DONE-entry edge only, from the final shift state:
  - sign, mag, bcd = shift[19:8].
  - of_out = of_in & (diff != 0).
  - out_valid is set on the same edge.
- DONE:
  - out_valid = 1; all outputs held stable while out_ready = 0.
  - On out_valid & out_ready, clear out_valid and go to IDLE.
  - sign/mag/bcd/of_out keep their last values after the transfer.
- in_valid is ignored outside IDLE; no input is buffered.
- Special values:
  - 8'h80 -> sign 1, mag 128, bcd 12'h128.
  - 8'h00 -> sign 0, mag 0, bcd 0, of_out 0 regardless of of_in.

## Timing
- Reset (reset = 0), asynchronous:
  - State goes to IDLE, counter to 0.
  - out_valid, sign, mag, bcd, of_out all 0.
  - in_ready = 1 (decoded from IDLE).
- Reset mid-operation (NEG/CONV/DONE) abandons the transaction; no out_valid is produced for it.
- Latency, with the acceptance edge as E0:
  - NEG executes on E1; CONV on E2..E9.
  - out_valid is high after E9, i.e. 9 clocks after acceptance.
- Throughput: with out_ready held 1, the output transfers on E10 and in_ready is high after E10. Next acceptance is at E11 earliest, i.e. 11 cycles per result.
- Backpressure: out_ready low stalls in DONE indefinitely, with outputs stable and in_ready 0.
- out_valid & out_ready in the same cycle as a new in_valid: the new input is not accepted that cycle, because in_ready is still 0.
- All outputs are registered; in_ready is combinational from state only.

## Test plan
- Reset: assert reset low mid-CONV.
  - Response: out_valid = 0, mag = 0, bcd = 0, in_ready = 1 immediately, with no clock edge.
  - After release, a fresh diff = 8'h05 yields mag = 5, bcd = 12'h005.
- Negative values, of_in = 0:
  - diff = 8'hFF -> sign 1, mag 1, bcd 12'h001.
  - diff = 8'h9C -> sign 1, mag 100, bcd 12'h100.
  - out_valid rises exactly 9 clocks after acceptance.
- Extremes:
  - 8'h80 -> sign 1, mag 128, bcd 12'h128.
  - 8'h7F -> sign 0, mag 127, bcd 12'h127.
- Overflow masking:
  - diff = 8'h00, of_in = 1 -> of_out 0.
  - diff = 8'h40, of_in = 1 -> of_out 1, bcd 12'h064.
- Backpressure: hold out_ready = 0 for 20 cycles in DONE.
  - Outputs stable, in_ready 0, in_valid pulses ignored.
  - Release -> one transfer, then IDLE.
- Exhaustive sweep: all 256 diff values back-to-back with out_ready = 1.
  - Each result matches a reference model.
  - Acceptances occur every 11 cycles.
